// File: rtl/rf_write_buffer.sv
// rf_write_buffer: in-order write FIFO feeding the register file write port, with forwarding lookups (RF_WRITE_BUFFER_FORWARD_EN).
module rf_write_buffer #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 16,
  parameter int REG_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [REG_W-1:0]         in_reg,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     rf_hold,
  output logic [REG_W-1:0]         writeRegSel,
  output logic [DATA_W-1:0]        writeData,
  output logic                     writeEn,
  input  logic [REG_W-1:0]         look1Sel,
  input  logic [REG_W-1:0]         look2Sel,
  output logic                     look1Hit,
  output logic                     look2Hit,
  output logic [DATA_W-1:0]        look1Data,
  output logic [DATA_W-1:0]        look2Data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);
  localparam int PW = $clog2(DEPTH);
  logic [REG_W-1:0] regMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [PW-1:0] head, tail;
  logic push;
  assign in_ready = count != (PW+1)'(DEPTH);
  assign push = in_valid & in_ready;
  assign writeEn = (count != '0) & ~rf_hold;
  assign writeRegSel = regMem[head];
  assign writeData = dataMem[head];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regMem[i] <= '0;
        dataMem[i] <= '0;
      end
    end else begin
      if (push) begin
        regMem[tail] <= in_reg;
        dataMem[tail] <= in_data;
        tail <= tail + 1'b1;
      end
      if (writeEn) head <= head + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(writeEn);
      err <= in_valid & ~in_ready;
    end
  end
`ifdef RF_WRITE_BUFFER_FORWARD_EN
  logic [PW-1:0] scanIdx;
  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    look1Hit = 1'b0;
    look2Hit = 1'b0;
    look1Data = '0;
    look2Data = '0;
    scanIdx = head;
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = head + PW'(k);
      if ((PW+1)'(k) < count && regMem[scanIdx] == look1Sel) begin
        look1Hit = 1'b1;
        look1Data = dataMem[scanIdx];
      end
      if ((PW+1)'(k) < count && regMem[scanIdx] == look2Sel) begin
        look2Hit = 1'b1;
        look2Data = dataMem[scanIdx];
      end
    end
  end
`else
  logic unusedSel;
  assign unusedSel = ^{look1Sel, look2Sel};
  assign look1Hit = 1'b0;
  assign look2Hit = 1'b0;
  assign look1Data = '0;
  assign look2Data = '0;
`endif
endmodule

// File: tb/tb_rf_write_buffer.sv
// tb_rf_write_buffer: directed stimulus checked every cycle against a queue model of the write buffer.
module tb_rf_write_buffer;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, rf_hold = 0;
  logic [2:0] in_reg = 0, look1Sel = 0, look2Sel = 0;
  logic [15:0] in_data = 0;
  logic in_ready, writeEn, look1Hit, look2Hit, err;
  logic [2:0] writeRegSel;
  logic [15:0] writeData, look1Data, look2Data;
  logic [2:0] count;
  int checks = 0, errors = 0;
  typedef struct { logic [2:0] r; logic [15:0] d; } entry_t;
  entry_t q[$];
  logic expErr = 0;

  rf_write_buffer #(.DEPTH(DEPTH), .DATA_W(16), .REG_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_reg(in_reg), .in_data(in_data),
    .in_ready(in_ready), .rf_hold(rf_hold), .writeRegSel(writeRegSel), .writeData(writeData),
    .writeEn(writeEn), .look1Sel(look1Sel), .look2Sel(look2Sel), .look1Hit(look1Hit),
    .look2Hit(look2Hit), .look1Data(look1Data), .look2Data(look2Data), .count(count), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lookModel(input logic [2:0] sel, output logic hit, output logic [15:0] d);
    hit = 0;
    d = 0;
`ifdef RF_WRITE_BUFFER_FORWARD_EN
    foreach (q[i]) if (q[i].r == sel) begin
      hit = 1;
      d = q[i].d;
    end
`endif
  endtask

  task automatic compare();
    logic h1, h2;
    logic [15:0] d1, d2;
    lookModel(look1Sel, h1, d1);
    lookModel(look2Sel, h2, d2);
    chk("count", count, q.size());
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("writeEn", writeEn, q.size() != 0 && !rf_hold);
    chk("err", err, expErr);
    if (q.size() != 0) begin
      chk("writeRegSel", writeRegSel, q[0].r);
      chk("writeData", writeData, q[0].d);
    end
    chk("look1Hit", look1Hit, h1);
    chk("look1Data", look1Data, d1);
    chk("look2Hit", look2Hit, h2);
    chk("look2Data", look2Data, d2);
  endtask

  task automatic tick();
    bit full;
    @(negedge clk);
    compare();
    full = q.size() >= DEPTH;
    expErr = in_valid && full;
    if (q.size() != 0 && !rf_hold) void'(q.pop_front());
    if (in_valid && !full) q.push_back('{in_reg, in_data});
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] r, input logic [15:0] d);
    in_valid = 1;
    in_reg = r;
    in_data = d;
    tick();
    in_valid = 0;
  endtask

  initial begin
    #12;
    chk("rst count", count, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst writeEn", writeEn, 0);
    chk("rst err", err, 0);
    chk("rst writeRegSel", writeRegSel, 0);
    chk("rst writeData", writeData, 0);
    chk("rst look1Hit", look1Hit, 0);
    chk("rst look1Data", look1Data, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    push(3, 16'h1234);
    chk("s1 writeEn", writeEn, 1);
    chk("s1 writeRegSel", writeRegSel, 3);
    chk("s1 writeData", writeData, 16'h1234);
    tick();
    chk("s1 count", count, 0);
    chk("s1 writeEn idle", writeEn, 0);

    rf_hold = 1;
    for (int i = 1; i <= 5; i++) push(3'(i), 16'h1000 + 16'(i));
    chk("s2 count", count, 4);
    chk("s2 in_ready", in_ready, 0);
    chk("s2 err", err, 1);
    tick();
    chk("s2 err pulse", err, 0);
    rf_hold = 0;
    chk("s2 head", writeData, 16'h1001);
    for (int i = 0; i < 4; i++) tick();
    chk("s2 drained", count, 0);

    rf_hold = 1;
    push(2, 16'hAAAA);
    push(2, 16'hBBBB);
    look1Sel = 2;
    look2Sel = 6;
    #1;
`ifdef RF_WRITE_BUFFER_FORWARD_EN
    chk("s3 look1Hit", look1Hit, 1);
    chk("s3 look1Data", look1Data, 16'hBBBB);
`else
    chk("s3 look1Hit", look1Hit, 0);
    chk("s3 look1Data", look1Data, 0);
`endif
    chk("s3 look2Hit", look2Hit, 0);
    chk("s3 look2Data", look2Data, 0);
    tick();
    rf_hold = 0;
    chk("s3 oldest first", writeData, 16'hAAAA);
    tick();
    tick();

    for (int i = 0; i < 3 * DEPTH; i++) begin
      look1Sel = 3'($urandom);
      look2Sel = 3'(i);
      push(3'(i), 16'($urandom));
      in_valid = (i != 3 * DEPTH - 1);
    end
    in_valid = 0;
    tick();
    tick();

    rf_hold = 1;
    push(1, 16'h0101);
    push(4, 16'h0404);
    push(7, 16'h0707);
    look1Sel = 4;
    rf_hold = 0;
    #1;
    chk("s5 writeEn pre", writeEn, 1);
    rst_n = 0;
    #1;
    chk("s5 writeEn async", writeEn, 0);
    chk("s5 count async", count, 0);
    chk("s5 look1Hit async", look1Hit, 0);
    q.delete();
    expErr = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
